// File: rtl/ofdm_tx_pkg.sv
// Shared OFDM TX constants and the cyclic-prefix reader state encoding.
package ofdm_tx_pkg;
  localparam int unsigned FFT_N       = 64;
  localparam int unsigned FFT_LGN     = 6;
  localparam int unsigned SAMPLE_W    = 32;
  localparam int unsigned CP_LEN_DFLT = 16;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_CP   = 2'd1,
    RD_BODY = 2'd2
  } rd_state_t;
endpackage

// File: rtl/ofdm_cp_insert_if.sv
// Sample-stream bundle of the CP inserter: IFFT-side strobe input, DAC-side valid/ready output.
interface ofdm_cp_insert_if
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned IW = SAMPLE_W / 2
) ();
  logic            i_ce;
  logic            i_sync;
  logic [2*IW-1:0] i_sample;
  logic            o_in_ready;
  logic            o_valid;
  logic            i_ready;
  logic [2*IW-1:0] o_sample;
  logic            o_sof;
  logic            o_eos;
  logic            o_err;

  modport slave (
    input  i_ce, i_sync, i_sample, i_ready,
    output o_in_ready, o_valid, o_sample, o_sof, o_eos, o_err
  );

  modport master (
    output i_ce, i_sync, i_sample, i_ready,
    input  o_in_ready, o_valid, o_sample, o_sof, o_eos, o_err
  );
endinterface

// File: rtl/cp_pingpong_ram.sv
// Two-bank symbol store: synchronous write, asynchronous (distributed) read.
module cp_pingpong_ram
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned AW = FFT_LGN + 1,
  parameter int unsigned DW = SAMPLE_W
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  localparam int unsigned DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ofdm_cp_insert.sv
// Buffers 64-sample IFFT symbols in a ping-pong store and replays each one
// with its last CP_LEN samples prepended as a cyclic prefix.
module ofdm_cp_insert
  import ofdm_tx_pkg::*;
#(
  parameter int unsigned IW     = SAMPLE_W / 2,
  parameter int unsigned LGN    = FFT_LGN,
  parameter int unsigned CP_LEN = CP_LEN_DFLT
) (
  input logic             i_clk,
  input logic             i_reset_n,
  ofdm_cp_insert_if.slave bus
);
  localparam int unsigned    N        = 2 ** LGN;
  localparam int unsigned    SW       = 2 * IW;
  localparam logic [LGN-1:0] IDX_LAST = LGN'(N - 1);
  localparam logic [LGN-1:0] CP_FIRST = LGN'(N - CP_LEN);

  logic [1:0]     full;
  logic           wr_bank;
  logic           rd_bank;
  logic           aligned;
  logic [LGN-1:0] wr_idx;
  logic [LGN-1:0] rd_idx;
  rd_state_t      state;

  logic           accept;
  logic           wr_en;
  logic [LGN-1:0] wr_addr_idx;
  logic           full_set;
  logic           full_clr;
  logic           advance;
  logic           rd_first;
  logic           rd_last;
  logic           next_full;
  logic [SW-1:0]  rd_data;

  assign bus.o_in_ready = !full[wr_bank];
  assign accept         = bus.i_ce && bus.o_in_ready;
  assign wr_en          = accept && (bus.i_sync || aligned);
  assign wr_addr_idx    = bus.i_sync ? '0 : wr_idx;
  assign full_set       = wr_en && (wr_addr_idx == IDX_LAST);

  assign advance   = !bus.o_valid || bus.i_ready;
  assign rd_first  = (state == RD_CP) && (rd_idx == CP_FIRST);
  assign rd_last   = (state == RD_BODY) && (rd_idx == IDX_LAST);
  assign full_clr  = advance && rd_last;
  // A bank completing this very cycle counts, so back-to-back symbols leave no gap.
  assign next_full = full[!rd_bank] || (full_set && (wr_bank != rd_bank));

  cp_pingpong_ram #(
    .AW(LGN + 1),
    .DW(SW)
  ) u_ram (
    .clk  (i_clk),
    .we   (wr_en),
    .waddr({wr_bank, wr_addr_idx}),
    .wdata(bus.i_sample),
    .raddr({rd_bank, rd_idx}),
    .rdata(rd_data)
  );

  // Writer: align on i_sync, fill the current bank, hand it over when complete.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_bank   <= 1'b0;
      wr_idx    <= '0;
      aligned   <= 1'b0;
      bus.o_err <= 1'b0;
    end else begin
      bus.o_err <= 1'b0;
      if (wr_en) begin
        if (bus.i_sync) begin
          aligned   <= 1'b1;
          bus.o_err <= (wr_idx != '0);
        end
        if (full_set) begin
          wr_bank <= !wr_bank;
          wr_idx  <= '0;
        end else begin
          wr_idx <= wr_addr_idx + LGN'(1);
        end
      end
    end
  end

  // Write-set and read-clear always hit different banks.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      full <= '0;
    end else begin
      if (full_set) full[wr_bank] <= 1'b1;
      if (full_clr) full[rd_bank] <= 1'b0;
    end
  end

  // Reader: CP tail of the symbol, then the full body, into the output register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= RD_IDLE;
      rd_bank      <= 1'b0;
      rd_idx       <= '0;
      bus.o_valid  <= 1'b0;
      bus.o_sof    <= 1'b0;
      bus.o_eos    <= 1'b0;
      bus.o_sample <= '0;
    end else if (advance) begin
      unique case (state)
        RD_IDLE: begin
          bus.o_valid <= 1'b0;
          bus.o_sof   <= 1'b0;
          bus.o_eos   <= 1'b0;
          if (full[rd_bank]) begin
            state  <= RD_CP;
            rd_idx <= CP_FIRST;
          end
        end
        RD_CP: begin
          bus.o_valid  <= 1'b1;
          bus.o_sample <= rd_data;
          bus.o_sof    <= rd_first;
          bus.o_eos    <= 1'b0;
          if (rd_idx == IDX_LAST) begin
            state  <= RD_BODY;
            rd_idx <= '0;
          end else begin
            rd_idx <= rd_idx + LGN'(1);
          end
        end
        RD_BODY: begin
          bus.o_valid  <= 1'b1;
          bus.o_sample <= rd_data;
          bus.o_sof    <= 1'b0;
          bus.o_eos    <= rd_last;
          if (rd_last) begin
            rd_bank <= !rd_bank;
            rd_idx  <= CP_FIRST;
            state   <= next_full ? RD_CP : RD_IDLE;
          end else begin
            rd_idx <= rd_idx + LGN'(1);
          end
        end
        default: state <= RD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ofdm_cp_insert.sv
// Directed/randomized bench for ofdm_cp_insert with a symbol-level reference model.
module tb_ofdm_cp_insert;
  import ofdm_tx_pkg::*;

  localparam int unsigned N  = FFT_N;
  localparam int unsigned CP = CP_LEN_DFLT;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ofdm_cp_insert_if #(.IW(SAMPLE_W / 2)) bus ();

  ofdm_cp_insert #(
    .IW    (SAMPLE_W / 2),
    .LGN   (FFT_LGN),
    .CP_LEN(CP)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [33:0] exp_q[$];
  logic [31:0] part[$];
  bit          aligned_m   = 1'b0;
  bit          err_pending = 1'b0;
  bit          rand_ready  = 1'b0;
  bit          saw_stall   = 1'b0;
  bit          stalled     = 1'b0;
  logic [34:0] held;
  logic [33:0] mon_exp;
  int          run     = 0;
  int          max_run = 0;
  int          out_cnt = 0;

  // Reference: a completed symbol expands to its last CP samples followed by all N.
  task automatic model_accept(input logic [31:0] s, input logic sync);
    if (sync) begin
      if (part.size() != 0) err_pending = 1'b1;
      part.delete();
      part.push_back(s);
      aligned_m = 1'b1;
    end else if (aligned_m) begin
      part.push_back(s);
    end
    if (part.size() == N) begin
      for (int i = N - CP; i < N; i++) exp_q.push_back({part[i], i == N - CP, 1'b0});
      for (int i = 0; i < N; i++) exp_q.push_back({part[i], 1'b0, i == N - 1});
      part.delete();
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    part.delete();
    aligned_m   = 1'b0;
    err_pending = 1'b0;
  endtask

  task automatic step();
    logic exp_err;
    @(posedge clk);
    #2;
    exp_err     = err_pending;
    err_pending = 1'b0;
    checks++;
    assert (bus.o_err === exp_err) else begin
      errors++;
      $error("FAIL o_err got %b exp %b", bus.o_err, exp_err);
    end
    bus.i_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic drive_sample(input logic [31:0] s, input logic sync);
    int budget = 0;
    bus.i_ce = 1'b0;
    while (bus.o_in_ready !== 1'b1 && budget < 500) begin
      saw_stall = 1'b1;
      step();
      budget++;
    end
    checks++;
    assert (bus.o_in_ready === 1'b1) else begin
      errors++;
      $error("FAIL in_ready_wait got %b exp 1", bus.o_in_ready);
    end
    bus.i_ce     = 1'b1;
    bus.i_sync   = sync;
    bus.i_sample = s;
    model_accept(s, sync);
    step();
    bus.i_ce   = 1'b0;
    bus.i_sync = 1'b0;
  endtask

  task automatic send_rand_symbol();
    for (int k = 0; k < N; k++) drive_sample($urandom, k == 0);
  endtask

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || bus.o_valid !== 1'b0) && budget < 3000) begin
      step();
      budget++;
    end
    checks++;
    assert (exp_q.size() == 0 && bus.o_valid === 1'b0) else begin
      errors++;
      $error("FAIL drain got %0d pending valid=%b exp 0 pending valid=0", exp_q.size(), bus.o_valid);
    end
  endtask

  // Output monitor: handshake transfers against the model, hold-while-stalled, run length.
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      stalled = 1'b0;
      run     = 0;
    end else begin
      if (stalled) begin
        checks++;
        assert ({bus.o_valid, bus.o_sample, bus.o_sof, bus.o_eos} === held) else begin
          errors++;
          $error("FAIL hold got %h exp %h", {bus.o_valid, bus.o_sample, bus.o_sof, bus.o_eos}, held);
        end
      end
      if (bus.o_valid === 1'b1) run++;
      else run = 0;
      if (run > max_run) max_run = run;
      if (bus.o_valid === 1'b1 && bus.i_ready === 1'b1) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_output got %h exp none", bus.o_sample);
        end
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          checks++;
          assert ({bus.o_sample, bus.o_sof, bus.o_eos} === mon_exp) else begin
            errors++;
            $error("FAIL out_data got %h exp %h", {bus.o_sample, bus.o_sof, bus.o_eos}, mon_exp);
          end
        end
        out_cnt++;
      end
      stalled = (bus.o_valid === 1'b1) && (bus.i_ready !== 1'b1);
      held    = {bus.o_valid, bus.o_sample, bus.o_sof, bus.o_eos};
    end
  end

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog got timeout exp finish");
  end

  initial begin
    int base;
    int budget;
    bus.i_ce     = 1'b0;
    bus.i_sync   = 1'b0;
    bus.i_sample = '0;
    bus.i_ready  = 1'b1;

    // Reset values, checked before any clock edge.
    #1 rst_n = 1'b0;
    #2;
    checks++;
    assert ({bus.o_valid, bus.o_sof, bus.o_eos, bus.o_err} === 4'b0000) else begin
      errors++;
      $error("FAIL reset_outs got %b exp 0000", {bus.o_valid, bus.o_sof, bus.o_eos, bus.o_err});
    end
    checks++;
    assert (bus.o_in_ready === 1'b1) else begin
      errors++;
      $error("FAIL reset_in_ready got %b exp 1", bus.o_in_ready);
    end
    #10 rst_n = 1'b1;
    step();

    // Junk before the first sync is dropped.
    for (int k = 0; k < 10; k++) drive_sample($urandom, 1'b0);
    send_rand_symbol();
    drain();

    // Single ramp symbol with latency check.
    for (int k = 0; k < N; k++) drive_sample({16'(k), 16'(-k)}, k == 0);
    checks++;
    assert (bus.o_valid === 1'b0) else begin
      errors++;
      $error("FAIL lat_c0 got %b exp 0", bus.o_valid);
    end
    step();
    checks++;
    assert (bus.o_valid === 1'b0) else begin
      errors++;
      $error("FAIL lat_c1 got %b exp 0", bus.o_valid);
    end
    step();
    checks++;
    assert ({bus.o_valid, bus.o_sof, bus.o_sample[31:16]} === {2'b11, 16'(N - CP)}) else begin
      errors++;
      $error("FAIL lat_c2 got %h exp %h", {bus.o_valid, bus.o_sof, bus.o_sample[31:16]}, {2'b11, 16'(N - CP)});
    end
    drain();

    // Three back-to-back symbols: continuous output, writer back-pressured.
    saw_stall = 1'b0;
    max_run   = 0;
    for (int s = 0; s < 3; s++) send_rand_symbol();
    drain();
    checks++;
    assert (max_run == 3 * (N + CP)) else begin
      errors++;
      $error("FAIL b2b_run got %0d exp %0d", max_run, 3 * (N + CP));
    end
    checks++;
    assert (saw_stall == 1'b1) else begin
      errors++;
      $error("FAIL b2b_in_ready_drop got %b exp 1", saw_stall);
    end

    // Random downstream back-pressure.
    rand_ready = 1'b1;
    for (int s = 0; s < 2; s++) send_rand_symbol();
    drain();
    rand_ready  = 1'b0;
    bus.i_ready = 1'b1;
    step();

    // Early sync at wr_idx=30 discards the partial symbol.
    for (int k = 0; k < 30; k++) drive_sample($urandom, k == 0);
    send_rand_symbol();
    drain();

    // Asynchronous reset in the middle of a symbol.
    send_rand_symbol();
    base   = out_cnt;
    budget = 0;
    while (out_cnt - base < 40 && budget < 500) begin
      step();
      budget++;
    end
    checks++;
    assert (out_cnt - base >= 40) else begin
      errors++;
      $error("FAIL rst_wait got %0d exp 40", out_cnt - base);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    assert ({bus.o_valid, bus.o_sof, bus.o_eos, bus.o_err} === 4'b0000) else begin
      errors++;
      $error("FAIL midrst_outs got %b exp 0000", {bus.o_valid, bus.o_sof, bus.o_eos, bus.o_err});
    end
    step();
    step();
    #1 rst_n = 1'b1;
    step();
    checks++;
    assert (bus.o_in_ready === 1'b1) else begin
      errors++;
      $error("FAIL midrst_in_ready got %b exp 1", bus.o_in_ready);
    end
    for (int k = 0; k < 100; k++) step();
    for (int k = 0; k < 5; k++) drive_sample($urandom, 1'b0);
    for (int k = 0; k < 20; k++) step();
    send_rand_symbol();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ofdm_cp_insert.md
Name: ofdm_cp_insert

Overview:
- Consumes the 64-point IFFT output stream: 32-bit samples qualified by i_ce, with i_sync marking the first sample of each symbol.
- Buffers each time-domain symbol in a ping-pong store and emits it with a cyclic prefix of CP_LEN samples prepended.
- Output is a valid/ready stream toward the TX sample path / DAC FIFO; upstream is stalled through o_in_ready, which gates the IFFT clock enable.

Parameters:
- IW, 16, width of each real/imag component; a sample is 2*IW bits, real in the high half.
- LGN, 6, log2 of symbol length N (N=64).
- CP_LEN, 16, cyclic prefix length in samples; legal range 1..N.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_ce  in  1  input sample strobe (IFFT o_result valid).
- i_sync  in  1  marks the first sample of a symbol; only meaningful with i_ce.
- i_sample  in  2*IW  time-domain sample.
- o_in_ready  out  1  write bank free; upstream must hold i_ce low while this is 0.
- o_valid  out  1  o_sample valid.
- i_ready  in  1  downstream accepts o_sample.
- o_sample  out  2*IW  output sample.
- o_sof  out  1  high with the first CP sample of a symbol.
- o_eos  out  1  high with the last body sample of a symbol.
- o_err  out  1  one-cycle pulse: partial symbol discarded.

Behaviour:
- Reset (async, i_reset_n=0):
  - Cleared: o_valid, o_sof, o_eos, o_err, full[1:0], wr_bank, rd_bank, wr_idx, aligned, read state (IDLE).
  - o_in_ready then reads 1.
  - Storage contents are not reset.
  - Reset mid-symbol drops all buffered and in-flight data. No stale sample is emitted after release.
- Write side:
  - Accepted sample = i_ce && o_in_ready.
  - o_in_ready = !full[wr_bank], combinational.
  - Accepted samples are discarded until the first i_sync; aligned is then set.
  - Accepted sample with i_sync: written at index 0 of wr_bank, wr_idx <= 1.
  - Otherwise, when aligned: written at wr_idx, wr_idx increments.
  - Write at index N-1: full[wr_bank] <= 1, wr_bank toggles, wr_idx <= 0.
  - i_sync with wr_idx != 0: partial symbol discarded, restart at index 0 of the same bank, o_err pulses for one cycle.
  - i_ce while o_in_ready=0: upstream protocol violation, sample ignored.
- Read side FSM: IDLE, CP, BODY.
  - IDLE: if full[rd_bank], go to CP with rd_idx = N-CP_LEN.
  - CP: emit rd_idx. After emitting N-1, go to BODY with rd_idx = 0.
  - BODY: emit rd_idx. After emitting N-1: clear full[rd_bank], toggle rd_bank. If the new rd_bank is full, go straight to CP with no bubble; else go to IDLE.
  - Sequence per symbol is indices N-CP_LEN..N-1 then 0..N-1, N+CP_LEN samples in total (80 by default).
- Output register:
  - Advances when !o_valid || i_ready.
  - o_valid/o_sample/o_sof/o_eos hold stable while o_valid && !i_ready.
  - o_sof is set on the first CP sample; o_eos on the last body sample.
- Latency: first CP sample appears on o_valid 2 cycles after the accepted 64th input sample, with an idle reader and i_ready=1.
- Concurrency:
  - Write-set and read-clear of full[] target different banks in the same cycle; both take effect.
  - The writer never writes a full bank, so the reader's bank is never overwritten.
- Throughput: output needs N+CP_LEN cycles per N inputs. o_in_ready deasserts periodically under continuous input; this is expected, and no samples are lost.
- Storage: 2*N x 2*IW, one synchronous write port, one asynchronous read port (distributed RAM).
  - Write address {wr_bank, wr_idx}; read address {rd_bank, rd_idx}.

Decomposition:
- Package ofdm_tx_pkg: FFT_N=64, FFT_LGN=6, SAMPLE_W=32, default CP_LEN=16, read FSM state enum (IDLE/CP/BODY).
- Sub-module cp_pingpong_ram: 2*N-entry dual-port storage, sync write, async read.
- Bank/FSM control stays in ofdm_cp_insert.

Test Plan:
- Single symbol, sample k = {k, -k}, k=0..63, i_sync on k=0, i_ready=1 -> 80 outputs: real parts 48..63 then 0..63. o_sof on output 1, o_eos on output 80. o_valid rises 2 cycles after the k=63 strobe.
- Three back-to-back symbols, i_ce held high whenever o_in_ready=1 -> 240 consecutive o_valid cycles with no bubble. o_in_ready drops while both banks are full. Data matches per symbol.
- Random i_ready (50%) on two symbols -> o_sample/o_sof/o_eos hold stable while stalled; exact 160-sample sequence, no duplicates or drops.
- 10 junk samples before the first i_sync, then one symbol -> junk never appears; output is exactly the 80-sample CP+body of the synced symbol.
- i_sync at wr_idx=30 -> o_err pulses one cycle. The 30 partial samples are discarded; the following 64 samples form the emitted symbol.
- Assert i_reset_n=0 after 40 outputs of a symbol -> o_valid/o_sof/o_eos/o_err drop to 0 immediately, without waiting for a clock. After release, o_in_ready=1 and nothing is emitted until a new synced 64-sample symbol is written.
